el2_trace_capture: RTL and testbench
====================================

Name: el2_trace_capture

Overview:
- Downstream consumer of the per-retirement trace packet (el2_trace_pkt_t) driven by the core's trace port.
- Filters retirements, buffers them in a synchronous FIFO and drains them to a debug/trace sink through a valid/ready handshake.
- Tracks dropped records on overflow and flags the first record after any loss.
- Sits between the core complex trace outputs and the SoC trace/debug fabric.

Parameters:
- DEPTH, 8, FIFO entries; power of 2, at least 2.
- HWM, 6, high-water threshold for hwm output; 1 to DEPTH.
- CNTW, 16, width of the saturating drop counter.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-high
- trace_pkt  in  el2_trace_pkt_t  retirement trace packet from the core
- cap_en  in  1  capture enable
- exc_only  in  1  capture only retirements with trace_rv_i_exception_ip or trace_rv_i_interrupt_ip set
- flush  in  1  discard all buffered records and any pending-overflow mark
- drop_clr  in  1  clear drop_cnt
- out_valid  out  1  head record available
- out_ready  in  1  sink accepts head record
- out_rec  out  el2_trace_rec_t  head record
- count  out  $clog2(DEPTH)+1  current occupancy
- hwm  out  1  count >= HWM
- drop_cnt  out  CNTW  records lost to full FIFO, saturating

Behaviour:
- Reset values: out_valid=0, out_rec=0, count=0, hwm=0, drop_cnt=0. Internal state after reset: pointers 0, ovf_pend=0.
- capture = cap_en & trace_rv_i_valid_ip & (!exc_only | exception_ip | interrupt_ip).
- Record construction:
  - Record fields: addr, insn, tval, ecause, exc, intr, ovf.
  - ovf = ovf_pend at push time.
  - A successful push clears ovf_pend.
- pop = out_valid & out_ready.
- push = capture & (!full | pop) & !flush.
  - A push into a full FIFO is accepted when a pop occurs in the same cycle; count is unchanged.
- Drop condition: capture & full & !pop & !flush.
  - drop_cnt increments and saturates at 2^CNTW-1.
  - ovf_pend is set to 1.
- Latency: a record captured in cycle N is visible at out_rec with out_valid=1 in cycle N+1 if the FIFO was empty.
  - No bypass from input to output.
- out_rec shows the head entry, read combinationally from registered storage.
  - out_rec is held stable while out_valid & !out_ready.
  - Its value is don't-care when out_valid=0; the bench must not check it then.
- Pointers are $clog2(DEPTH)+1 bits wide. The MSB distinguishes full from empty.
  - full = (wr_ptr ^ rd_ptr) == {1'b1, 0...}.
  - empty = wr_ptr == rd_ptr.
  - Pointers wrap naturally modulo 2*DEPTH.
- count = wr_ptr - rd_ptr; out_valid = !empty; hwm = count >= HWM. All three are registered-state derived, with no combinational path from inputs.
- flush (highest priority):
  - Next cycle: pointers equal, count=0, ovf_pend=0.
  - A same-cycle capture is discarded and not counted as a drop.
  - A same-cycle pop has no additional effect.
  - drop_cnt is unaffected.
- drop_clr:
  - drop_cnt becomes 0 next cycle.
  - If a drop occurs in the same cycle, drop_cnt becomes 1 (clear then count).
- rst mid-operation: all state returns to reset values on the next edge, regardless of other inputs.
- cap_en deassertion does not affect buffered records; draining continues.
- Sink may hold out_ready=1 permanently; the FIFO then sustains one push and one pop per cycle.

Decomposition:
- Add to el2_pkg: typedef el2_trace_rec_t, packed, MSB first.
  - Fields: addr[31:0], insn[31:0], tval[31:0], ecause[4:0], exc, intr, ovf.
  - Total width 104 bits.
- One sub-module, el2_trace_fifo: generic synchronous FIFO.
  - Parameters: WIDTH, DEPTH.
  - Ports: clk, rst, flush, push, wdata, pop, rdata, full, empty, count.
- el2_trace_capture holds the filter, the drop counter, ovf_pend and the hwm logic.

Test Plan:
- Basic flow: cap_en=1, exc_only=0, out_ready=1, one packet with addr=0x1000, insn=0x00000013 → next cycle out_valid=1, out_rec.addr=0x1000, insn=0x13, ovf=0, count=1; the cycle after, count=0.
- Filter: exc_only=1, send 3 plain retirements, then one with exception=1, ecause=2 → exactly one record, ecause=2, exc=1.
- Overflow: out_ready=0, DEPTH=8, send 11 packets → count=8, hwm=1, drop_cnt=3.
  - Then out_ready=1 and send one more → after the 8 stored records drain, the 9th record has ovf=1 and addr equal to the 12th packet's address.
- Full with simultaneous pop: FIFO full, out_ready=1 and capture in the same cycle → drop_cnt unchanged, count stays 8, the new record is delivered last.
- Flush priority: 5 records buffered, ovf_pend=1, assert flush together with a capture → next cycle count=0, out_valid=0, drop_cnt unchanged. The next captured record has ovf=0.
- Saturation, clear and reset: CNTW=4, force 20 drops → drop_cnt=15.
  - drop_clr together with a drop → drop_cnt=1.
  - rst asserted mid-stream → all outputs 0 next cycle.

Source files
------------

// File: rtl/el2_pkg.sv
// Shared types for the core trace port and the captured trace record.
package el2_pkg;

  typedef struct packed {
    logic [31:0] trace_rv_i_insn_ip;
    logic [31:0] trace_rv_i_address_ip;
    logic        trace_rv_i_valid_ip;
    logic        trace_rv_i_exception_ip;
    logic [4:0]  trace_rv_i_ecause_ip;
    logic        trace_rv_i_interrupt_ip;
    logic [31:0] trace_rv_i_tval_ip;
  } el2_trace_pkt_t;

  // 104-bit buffered record; ovf marks the first record after a loss.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] insn;
    logic [31:0] tval;
    logic [4:0]  ecause;
    logic        exc;
    logic        intr;
    logic        ovf;
  } el2_trace_rec_t;

  localparam int TRACE_REC_W = $bits(el2_trace_rec_t);

endpackage

// File: rtl/el2_trace_fifo.sv
// Generic synchronous FIFO with an extra pointer bit to tell full from empty.
module el2_trace_fifo #(
  parameter int WIDTH = 104,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_pop;
  logic             do_push;

  assign full    = (wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}};
  assign empty   = (wr_ptr == rd_ptr);
  assign count   = wr_ptr - rd_ptr;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Head is gated to zero when empty so the output is clean out of reset.
  assign rdata = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush && do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/el2_trace_capture.sv
// Trace capture: filters retirements, buffers them and drains to a trace sink.
module el2_trace_capture
  import el2_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int HWM   = 6,
  parameter int CNTW  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  el2_trace_pkt_t          trace_pkt,
  input  logic                    cap_en,
  input  logic                    exc_only,
  input  logic                    flush,
  input  logic                    drop_clr,
  output logic                    out_valid,
  input  logic                    out_ready,
  output el2_trace_rec_t          out_rec,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    hwm,
  output logic [CNTW-1:0]         drop_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CNTW-1:0] CNT_MAX = '1;

  logic           capture;
  logic           push;
  logic           pop;
  logic           drop;
  logic           full;
  logic           empty;
  logic           ovf_pend;
  logic [CNTW-1:0] drop_cnt_nxt;
  el2_trace_rec_t wrec;

  assign capture = cap_en & trace_pkt.trace_rv_i_valid_ip &
                   (~exc_only | trace_pkt.trace_rv_i_exception_ip |
                    trace_pkt.trace_rv_i_interrupt_ip);

  assign out_valid = ~empty;
  assign pop       = out_valid & out_ready;
  assign push      = capture & (~full | pop) & ~flush;
  assign drop      = capture & full & ~pop & ~flush;
  assign hwm       = (count >= CW'(HWM));

  always_comb begin
    wrec        = '0;
    wrec.addr   = trace_pkt.trace_rv_i_address_ip;
    wrec.insn   = trace_pkt.trace_rv_i_insn_ip;
    wrec.tval   = trace_pkt.trace_rv_i_tval_ip;
    wrec.ecause = trace_pkt.trace_rv_i_ecause_ip;
    wrec.exc    = trace_pkt.trace_rv_i_exception_ip;
    wrec.intr   = trace_pkt.trace_rv_i_interrupt_ip;
    wrec.ovf    = ovf_pend;
  end

  // Clear is applied before the increment so a same-cycle drop lands as 1.
  always_comb begin
    drop_cnt_nxt = drop_clr ? '0 : drop_cnt;
    if (drop && drop_cnt_nxt != CNT_MAX) drop_cnt_nxt = drop_cnt_nxt + CNTW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
      ovf_pend <= 1'b0;
    end else begin
      drop_cnt <= drop_cnt_nxt;
      if (flush)     ovf_pend <= 1'b0;
      else if (drop) ovf_pend <= 1'b1;
      else if (push) ovf_pend <= 1'b0;
    end
  end

  el2_trace_fifo #(
    .WIDTH (TRACE_REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .wdata (wrec),
    .pop   (pop),
    .rdata (out_rec),
    .full  (full),
    .empty (empty),
    .count (count)
  );

endmodule

// File: tb/tb_el2_trace_capture.sv
// Directed bench for el2_trace_capture with hand-computed expectations.
module tb_el2_trace_capture;
  import el2_pkg::*;

  localparam int DEPTH = 8;
  localparam int HWM   = 6;
  localparam int CNTW  = 4;

  logic           clk = 1'b0;
  logic           rst;
  el2_trace_pkt_t trace_pkt;
  logic           cap_en;
  logic           exc_only;
  logic           flush;
  logic           drop_clr;
  logic           out_valid;
  logic           out_ready;
  el2_trace_rec_t out_rec;
  logic [3:0]     count;
  logic           hwm;
  logic [CNTW-1:0] drop_cnt;

  int n_total = 0;
  int n_pass  = 0;

  el2_trace_capture #(.DEPTH(DEPTH), .HWM(HWM), .CNTW(CNTW)) dut (
    .clk       (clk),
    .rst       (rst),
    .trace_pkt (trace_pkt),
    .cap_en    (cap_en),
    .exc_only  (exc_only),
    .flush     (flush),
    .drop_clr  (drop_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_rec   (out_rec),
    .count     (count),
    .hwm       (hwm),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pkt(input logic [31:0] addr, input logic [31:0] insn,
                         input logic exc, input logic intr, input logic [4:0] ecause);
    trace_pkt = '0;
    trace_pkt.trace_rv_i_valid_ip     = 1'b1;
    trace_pkt.trace_rv_i_address_ip   = addr;
    trace_pkt.trace_rv_i_insn_ip      = insn;
    trace_pkt.trace_rv_i_exception_ip = exc;
    trace_pkt.trace_rv_i_interrupt_ip = intr;
    trace_pkt.trace_rv_i_ecause_ip    = ecause;
    trace_pkt.trace_rv_i_tval_ip      = addr ^ 32'hFFFF_0000;
  endtask

  task automatic send(input logic [31:0] addr);
    set_pkt(addr, 32'h0000_0013, 1'b0, 1'b0, 5'd0);
    tick();
    trace_pkt = '0;
  endtask

  initial begin
    rst = 1'b1; trace_pkt = '0; cap_en = 1'b0; exc_only = 1'b0;
    flush = 1'b0; drop_clr = 1'b0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_valid", 128'(out_valid), 128'd0);
    check("rst_count", 128'(count), 128'd0);
    check("rst_hwm", 128'(hwm), 128'd0);
    check("rst_drop", 128'(drop_cnt), 128'd0);
    check("rst_rec", 128'(out_rec), 128'd0);

    // basic flow
    cap_en = 1'b1; out_ready = 1'b1;
    send(32'h1000);
    check("basic_valid", 128'(out_valid), 128'd1);
    check("basic_addr", 128'(out_rec.addr), 128'h1000);
    check("basic_insn", 128'(out_rec.insn), 128'h13);
    check("basic_tval", 128'(out_rec.tval), 128'hFFFF_1000);
    check("basic_ovf", 128'(out_rec.ovf), 128'd0);
    check("basic_count1", 128'(count), 128'd1);
    tick();
    check("basic_count0", 128'(count), 128'd0);

    // exception-only filter
    exc_only = 1'b1;
    for (int i = 0; i < 3; i++) send(32'h2000 + 32'(i * 4));
    check("filt_plain", 128'(count), 128'd0);
    set_pkt(32'h2100, 32'h0000_0073, 1'b1, 1'b0, 5'd2);
    tick();
    trace_pkt = '0;
    check("filt_count", 128'(count), 128'd1);
    check("filt_addr", 128'(out_rec.addr), 128'h2100);
    check("filt_ecause", 128'(out_rec.ecause), 128'd2);
    check("filt_exc", 128'(out_rec.exc), 128'd1);
    tick();
    check("filt_drain", 128'(count), 128'd0);
    exc_only = 1'b0;

    // overflow: 11 packets into 8 entries
    out_ready = 1'b0;
    for (int i = 0; i < 11; i++) begin
      send(32'h3000 + 32'(i * 4));
      if (i == 4) check("hwm_below", 128'(hwm), 128'd0);
      if (i == 5) check("hwm_at", 128'(hwm), 128'd1);
    end
    check("ovf_count", 128'(count), 128'd8);
    check("ovf_hwm", 128'(hwm), 128'd1);
    check("ovf_drop", 128'(drop_cnt), 128'd3);
    check("ovf_head", 128'(out_rec.addr), 128'h3000);
    out_ready = 1'b1;
    send(32'h302C);
    check("fullpop_count", 128'(count), 128'd8);
    check("fullpop_drop", 128'(drop_cnt), 128'd3);
    for (int j = 1; j < 8; j++) begin
      check("drain_addr", 128'(out_rec.addr), 128'(32'h3000 + 32'(j * 4)));
      check("drain_ovf", 128'(out_rec.ovf), 128'd0);
      tick();
    end
    check("ovf_rec_addr", 128'(out_rec.addr), 128'h302C);
    check("ovf_rec_flag", 128'(out_rec.ovf), 128'd1);
    tick();
    check("ovf_empty", 128'(out_valid), 128'd0);

    // full with simultaneous pop: new record delivered last
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(32'h4000 + 32'(i * 4));
    check("fp_full", 128'(count), 128'd8);
    out_ready = 1'b1;
    send(32'h4100);
    check("fp_count", 128'(count), 128'd8);
    check("fp_drop", 128'(drop_cnt), 128'd3);
    for (int j = 0; j < 7; j++) tick();
    check("fp_last_addr", 128'(out_rec.addr), 128'h4100);
    check("fp_last_ovf", 128'(out_rec.ovf), 128'd0);
    tick();
    check("fp_empty", 128'(count), 128'd0);

    // flush priority with pending overflow
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) send(32'h5000 + 32'(i * 4));
    check("fl_pre_drop", 128'(drop_cnt), 128'd4);
    flush = 1'b1;
    send(32'h5100);
    flush = 1'b0;
    check("fl_count", 128'(count), 128'd0);
    check("fl_valid", 128'(out_valid), 128'd0);
    check("fl_hwm", 128'(hwm), 128'd0);
    check("fl_drop", 128'(drop_cnt), 128'd4);
    send(32'h5200);
    check("fl_next_addr", 128'(out_rec.addr), 128'h5200);
    check("fl_next_ovf", 128'(out_rec.ovf), 128'd0);
    check("fl_next_count", 128'(count), 128'd1);
    out_ready = 1'b1;
    tick();
    check("fl_drain", 128'(count), 128'd0);

    // saturation, clear with drop, clear alone
    out_ready = 1'b0;
    for (int i = 0; i < 28; i++) send(32'h6000 + 32'(i * 4));
    check("sat_drop", 128'(drop_cnt), 128'd15);
    drop_clr = 1'b1;
    send(32'h6200);
    check("clr_with_drop", 128'(drop_cnt), 128'd1);
    tick();
    drop_clr = 1'b0;
    check("clr_alone", 128'(drop_cnt), 128'd0);
    send(32'h6300);
    check("post_clr_drop", 128'(drop_cnt), 128'd1);

    // reset mid-stream overrides capture
    rst = 1'b1;
    set_pkt(32'h7000, 32'h13, 1'b0, 1'b0, 5'd0);
    tick();
    rst = 1'b0;
    trace_pkt = '0;
    check("mrst_valid", 128'(out_valid), 128'd0);
    check("mrst_count", 128'(count), 128'd0);
    check("mrst_hwm", 128'(hwm), 128'd0);
    check("mrst_drop", 128'(drop_cnt), 128'd0);
    check("mrst_rec", 128'(out_rec), 128'd0);
    send(32'h7100);
    check("mrst_ovf", 128'(out_rec.ovf), 128'd0);
    check("mrst_addr", 128'(out_rec.addr), 128'h7100);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
